jtdsp16_dec: RTL and testbench
==============================

JTDSP16_DEC -- requirements
Module: jtdsp16_dec

Interface
REQ-001 Parameter CACHE_DEPTH, default 15: number of instruction words the do-loop cache holds; legal range 1..15.
REQ-002 Parameter CNT_W, default 7: width of the loop repeat counter K.
REQ-003 Parameter IW, default 16: instruction word width; field positions below assume 16.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 cen  in  1: clock enable; no state change when low.
REQ-007 rom_dout  in  IW: instruction word fetched at the current PC.
REQ-008 t_field  out  5: decoded T field of the issued word.
REQ-009 r_field  out  3: destination register select.
REQ-010 short_imm  out  9: short immediate.
REQ-011 long_imm  out  IW: second word of a two-word instruction.
REQ-012 short_load, long_load  out  1 each: single-cycle load strobes.
REQ-013 pc_hold  out  1: high while replaying from the cache; the PC must not advance.
REQ-014 loop_busy  out  1: high from do issue until the last replay word issues.
REQ-015 loop_err  out  1: single-cycle strobe on an illegal word inside a do block.
REQ-016 issue  out  1: high when a valid decoded word is presented this cycle.

Function
REQ-017 Issue source: rom_dout in IDLE/IMM2/REC; cache[rd_ptr] in REPLAY.
REQ-018 All decoded outputs registered; one cen-cycle latency from source word to outputs.
REQ-019 Decode: T=0001? -> short_load=1, r_field={rom[11:9]}^3'b100, short_imm=rom[8:0]; T=01010 -> long_load on next word, long_imm=that word; T=01110 -> do instruction.
REQ-020 FSM states: IDLE, IMM2, REC, REPLAY.
REQ-021 IDLE: T=01010 -> IMM2; T=01110 with N=rom[10:7]>0 -> REC, latch N and K=rom[6:0]; otherwise stay.
REQ-022 IMM2: issue long_load=1, long_imm=rom_dout, return to IDLE; no decode of that word as an instruction.
REQ-023 REC: each cen cycle, write rom_dout to cache[wr_ptr], issue it normally, increment wr_ptr; after N words, go to REPLAY if K>1, else IDLE.
REQ-024 REPLAY: issue cache[rd_ptr] each cycle with pc_hold=1; rd_ptr wraps 0 after N-1; K decrements at each wrap; exit to IDLE when the pass with K==2 completes, so the body executes K times in total.
REQ-025 N=0 or N>CACHE_DEPTH: do is treated as NOP; state stays IDLE.
REQ-026 K=0 or K=1: single pass through REC, no REPLAY.
REQ-027 A T=01010 or T=01110 word inside REC: loop_err=1 for one cycle, word issued as NOP, FSM to IDLE, loop abandoned.
REQ-028 cen low: FSM, pointers, counters and outputs hold; strobes are not repeated.
REQ-029 Strobes (short_load, long_load, loop_err) are high for exactly one cen cycle.

Reset
REQ-030 On rst: FSM=IDLE; all strobes, issue, pc_hold and loop_busy=0; pointers and K=0; fields=0; cache contents undefined.
REQ-031 rst asserted mid-REC or mid-REPLAY aborts the loop; the first post-reset word decodes from IDLE.

Configuration
REQ-032 Macro JTDSP16_CACHE_EN: defined -> do-loop cache as specified; undefined -> no cache storage, T=01110 decodes as NOP, pc_hold, loop_busy and loop_err tied 0, and REC/REPLAY unreachable.

Structure
REQ-033 Shared package jtdsp16_pkg: T-field opcode constants (T_SHORT, T_LONG, T_DO), FSM state enum, field bit-position constants.
REQ-034 One sub-module, jtdsp16_dec_cache: CACHE_DEPTH x IW register array with wr/rd pointers and wrap logic.

Verification
REQ-035 rom=0x1A05 (T=00011) -> next cycle short_load=1, short_imm=0x005, r_field=3'b001.
REQ-036 rom=0x5000, then 0xBEEF -> long_load=1 with long_imm=0xBEEF on the second issue; 0xBEEF not decoded.
REQ-037 do N=3, K=4 followed by 3 NOP words -> 12 body issues total, pc_hold high for exactly 9 cycles, then loop_busy=0.
REQ-038 do N=2, K=1 -> 2 issues, pc_hold never asserted; do N=0 -> no state change.
REQ-039 Long immediate inside a do block -> loop_err pulse, FSM IDLE next cycle, pc_hold=0.
REQ-040 rst pulsed during REPLAY with cen toggling 50% -> all outputs 0 next cycle; the following word decodes normally; repeat with JTDSP16_CACHE_EN undefined and do words seen as NOP.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared opcode, field-position and FSM definitions for the jtdsp16 decoder.
package jtdsp16_pkg;

  localparam int T_MSB   = 15;
  localparam int T_LSB   = 11;
  localparam int R_MSB   = 11;
  localparam int R_LSB   = 9;
  localparam int IMM_MSB = 8;
  localparam int N_MSB   = 10;
  localparam int N_LSB   = 7;
  localparam int K_MSB   = 6;
  localparam int PTR_W   = 4;

  // T_SHORT is the upper four bits of T; the LSB is a don't-care.
  localparam logic [3:0] T_SHORT = 4'b0001;
  localparam logic [4:0] T_LONG  = 5'b01010;
  localparam logic [4:0] T_DO    = 5'b01110;
  localparam logic [2:0] R_XOR   = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IMM2   = 2'd1,
    REC    = 2'd2,
    REPLAY = 2'd3
  } state_t;

  function automatic logic t_is_short(input logic [4:0] t);
    return t[4:1] == T_SHORT;
  endfunction

endpackage

// File: rtl/jtdsp16_dec_cache.sv
// Do-loop body store: records N words during REC and replays them cyclically.
module jtdsp16_dec_cache
  import jtdsp16_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int IW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             start,
  input  logic             rec,
  input  logic             replay,
  input  logic [PTR_W-1:0] n_in,
  input  logic [IW-1:0]    wr_data,
  output logic [IW-1:0]    rd_data,
  output logic             wr_last,
  output logic             rd_last
);

  logic [PTR_W-1:0] n_q, n_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    mem_q [DEPTH];

  assign wr_last = wr_ptr_q == (n_q - PTR_W'(1));
  assign rd_last = rd_ptr_q == (n_q - PTR_W'(1));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    n_d      = n_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (start) begin
      n_d      = n_in;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (rec)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (replay) rd_ptr_d = rd_last ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (cen) begin
      n_q      <= n_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Body storage carries no reset; contents are only read after being recorded.
  always_ff @(posedge clk) begin
    if (cen && rec) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/jtdsp16_dec.sv
// DSP16 instruction decoder with registered outputs and a do-loop replay cache.
// Define JTDSP16_CACHE_EN to build the cache; without it do words decode as NOP.
module jtdsp16_dec
  import jtdsp16_pkg::*;
#(
  parameter int CACHE_DEPTH = 15,
  parameter int CNT_W       = 7,
  parameter int IW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [IW-1:0] rom_dout,
  output logic [4:0]    t_field,
  output logic [2:0]    r_field,
  output logic [8:0]    short_imm,
  output logic [IW-1:0] long_imm,
  output logic          short_load,
  output logic          long_load,
  output logic          pc_hold,
  output logic          loop_busy,
  output logic          loop_err,
  output logic          issue
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [4:0]       t_field_q, t_field_d;
  logic [2:0]       r_field_q, r_field_d;
  logic [8:0]       short_imm_q, short_imm_d;
  logic [IW-1:0]    long_imm_q, long_imm_d;
  logic             short_load_q, short_load_d;
  logic             long_load_q, long_load_d;
  logic             loop_err_q, loop_err_d;
  logic             issue_q, issue_d;

  logic [IW-1:0] src, cache_word;
  logic [4:0]    t_src;
  logic          is_long, is_do, do_ok, wr_last, rd_last;

  assign src     = (state_q == REPLAY) ? cache_word : rom_dout;
  assign t_src   = src[T_MSB:T_LSB];
  assign is_long = t_src == T_LONG;
  assign is_do   = t_src == T_DO;

`ifdef JTDSP16_CACHE_EN
  jtdsp16_dec_cache #(.DEPTH(CACHE_DEPTH), .IW(IW)) u_cache (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .start   ((state_q == IDLE) && do_ok),
    .rec     (state_q == REC),
    .replay  (state_q == REPLAY),
    .n_in    (rom_dout[N_MSB:N_LSB]),
    .wr_data (rom_dout),
    .rd_data (cache_word),
    .wr_last (wr_last),
    .rd_last (rd_last)
  );
  // A zero-length or oversized body cannot be cached, so the do falls through as NOP.
  assign do_ok = is_do && (rom_dout[N_MSB:N_LSB] != 4'd0)
                 && (32'(rom_dout[N_MSB:N_LSB]) <= CACHE_DEPTH);
`else
  assign cache_word = '0;
  assign wr_last    = 1'b0;
  assign rd_last    = 1'b0;
  assign do_ok      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    t_field_d    = t_field_q;
    r_field_d    = r_field_q;
    short_imm_d  = short_imm_q;
    long_imm_d   = long_imm_q;
    short_load_d = 1'b0;
    long_load_d  = 1'b0;
    loop_err_d   = 1'b0;
    issue_d      = 1'b0;
    if (cen) begin
      issue_d   = 1'b1;
      t_field_d = t_src;
      if (state_q != IMM2 && t_is_short(t_src)) begin
        short_load_d = 1'b1;
        r_field_d    = src[R_MSB:R_LSB] ^ R_XOR;
        short_imm_d  = src[IMM_MSB:0];
      end
      case (state_q)
        IDLE: begin
          if (is_long) begin
            state_d = IMM2;
          end else if (do_ok) begin
            state_d = REC;
            k_d     = CNT_W'(src[K_MSB:0]);
          end else if (is_do) begin
            t_field_d = '0;
          end
        end
        IMM2: begin
          t_field_d   = '0;
          long_load_d = 1'b1;
          long_imm_d  = rom_dout;
          state_d     = IDLE;
        end
        REC: begin
          if (is_long || is_do) begin
            loop_err_d = 1'b1;
            t_field_d  = '0;
            state_d    = IDLE;
          end else if (wr_last) begin
            state_d = (k_q > CNT_W'(1)) ? REPLAY : IDLE;
          end
        end
        REPLAY: begin
          // The recorded pass counts as one execution, so the pass seen with K==2 is the last.
          if (rd_last) begin
            if (k_q == CNT_W'(2)) state_d = IDLE;
            else                  k_d     = k_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      t_field_q    <= '0;
      r_field_q    <= '0;
      short_imm_q  <= '0;
      long_imm_q   <= '0;
      short_load_q <= 1'b0;
      long_load_q  <= 1'b0;
      loop_err_q   <= 1'b0;
      issue_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      t_field_q    <= t_field_d;
      r_field_q    <= r_field_d;
      short_imm_q  <= short_imm_d;
      long_imm_q   <= long_imm_d;
      short_load_q <= short_load_d;
      long_load_q  <= long_load_d;
      loop_err_q   <= loop_err_d;
      issue_q      <= issue_d;
    end
  end

  assign t_field    = t_field_q;
  assign r_field    = r_field_q;
  assign short_imm  = short_imm_q;
  assign long_imm   = long_imm_q;
  assign short_load = short_load_q;
  assign long_load  = long_load_q;
  assign loop_err   = loop_err_q;
  assign issue      = issue_q;
  assign pc_hold    = state_q == REPLAY;
  assign loop_busy  = (state_q == REC) || (state_q == REPLAY);

endmodule

// File: tb/tb_jtdsp16_dec.sv
// Self-checking bench for jtdsp16_dec: program-expansion reference model plus directed cases.
module tb_jtdsp16_dec;

  localparam int DEPTH = 15;
`ifdef JTDSP16_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cen;
  logic [15:0] rom_dout;
  logic [4:0]  t_field;
  logic [2:0]  r_field;
  logic [8:0]  short_imm;
  logic [15:0] long_imm;
  logic        short_load, long_load, pc_hold, loop_busy, loop_err, issue;

  logic [15:0] prog [256];
  logic [7:0]  pc = 8'd0;
  assign rom_dout = prog[pc];

  always #5 clk = ~clk;

  jtdsp16_dec #(.CACHE_DEPTH(DEPTH), .CNT_W(7), .IW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .rom_dout   (rom_dout),
    .t_field    (t_field),
    .r_field    (r_field),
    .short_imm  (short_imm),
    .long_imm   (long_imm),
    .short_load (short_load),
    .long_load  (long_load),
    .pc_hold    (pc_hold),
    .loop_busy  (loop_busy),
    .loop_err   (loop_err),
    .issue      (issue)
  );

  typedef struct packed {
    logic [4:0]  t;
    logic        sl;
    logic [2:0]  r;
    logic [8:0]  si;
    logic        ll;
    logic [15:0] li;
    logic        err;
  } out_t;

  out_t expq[$];
  out_t cur;
  int   vectors = 0, miscompares = 0;
  int   hold_cnt, busy_cnt, err_cnt, issue_cnt, exp_replays;

  function automatic out_t observed();
    return out_t'({t_field, short_load, r_field, short_imm, long_load, long_imm, loop_err});
  endfunction

  function automatic logic [38:0] all_out();
    return {t_field, r_field, short_imm, long_imm, short_load, long_load,
            pc_hold, loop_busy, loop_err, issue};
  endfunction

  // kind: 0 decoded normally, 1 NOP, 2 long immediate word, 3 illegal word in a do body
  task automatic emit(input logic [15:0] w, input int kind);
    out_t o;
    o = cur; o.sl = 1'b0; o.ll = 1'b0; o.err = 1'b0;
    case (kind)
      0: begin
        o.t = w[15:11];
        if (w[15:12] == 4'b0001) begin
          o.sl = 1'b1; o.r = w[11:9] ^ 3'b100; o.si = w[8:0];
        end
      end
      1: o.t = 5'd0;
      2: begin o.t = 5'd0; o.ll = 1'b1; o.li = w; end
      default: begin o.t = 5'd0; o.err = 1'b1; end
    endcase
    cur = o;
    expq.push_back(o);
  endtask

  // Expands the program into the sequence of issued words, unrolling do loops.
  task automatic build(input int len);
    int i, n, k;
    bit abandoned;
    logic [15:0] w, b;
    expq.delete(); cur = '0; exp_replays = 0; i = 0;
    while (i < len) begin
      w = prog[i]; n = int'(w[10:7]); k = int'(w[6:0]);
      if (w[15:11] == 5'b01010) begin
        emit(w, 0); emit(prog[i+1], 2); i += 2;
      end else if (w[15:11] == 5'b01110) begin
        if (!CACHE_EN || n == 0 || n > DEPTH) begin
          emit(w, 1); i++;
        end else begin
          emit(w, 0); abandoned = 1'b0;
          for (int j = 1; j <= n && !abandoned; j++) begin
            b = prog[i+j];
            if (b[15:11] == 5'b01010 || b[15:11] == 5'b01110) begin
              emit(b, 3); i = i + j + 1; abandoned = 1'b1;
            end else emit(b, 0);
          end
          if (!abandoned) begin
            for (int p = 2; p <= k; p++)
              for (int j = 1; j <= n; j++) begin
                emit(prog[i+j], 0); exp_replays++;
              end
            i = i + 1 + n;
          end
        end
      end else begin
        emit(w, 0); i++;
      end
    end
  endtask

  task automatic step(input bit c);
    bit adv;
    cen = c;
    adv = c && (pc_hold === 1'b0);
    if (c && pc_hold === 1'b1) hold_cnt++;
    @(posedge clk); #1;
    if (adv) pc = pc + 8'd1;
    if (loop_busy === 1'b1) busy_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(1'b0); step(1'b1); rst = 1'b0;
    pc = 8'd0; hold_cnt = 0; busy_cnt = 0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic run_prog(input int len, input bit rand_cen, input int budget);
    int   cyc;
    bit   c;
    out_t e, got;
    build(len);
    do_reset();
    err_cnt = 0; issue_cnt = 0; cyc = 0;
    while (expq.size() > 0 && cyc < budget) begin
      c = rand_cen ? 1'($urandom_range(0, 1)) : 1'b1;
      step(c); cyc++;
      vectors++;
      if (issue !== c) begin
        miscompares++;
        $display("FAIL issue_strobe cyc=%0d got=%b exp=%b", cyc, issue, c);
      end
      if (c) begin
        issue_cnt++;
        e = expq.pop_front(); got = observed();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL decode issue#%0d got=%h exp=%h", issue_cnt, got, e);
        end
        if (loop_err === 1'b1) begin
          err_cnt++; vectors++;
          if ({pc_hold, loop_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL err_exit got pc_hold,busy=%b exp=00", {pc_hold, loop_busy});
          end
        end
      end else begin
        vectors++;
        if ({short_load, long_load, loop_err} !== 3'b000) begin
          miscompares++;
          $display("FAIL strobe_repeat got=%b exp=000", {short_load, long_load, loop_err});
        end
      end
    end
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL timeout pending=%0d exp=0", expq.size());
    end
  endtask

  function automatic logic [15:0] rand_plain();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'b01010 || w[15:11] == 5'b01110) w[15:12] = 4'b0001;
    return w;
  endfunction

  task automatic gen_prog(output int len);
    int i, sel, n, k;
    clear_prog(); i = 0;
    while (i < 180) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        prog[i] = rand_plain(); i++;
      end else if (sel <= 5) begin
        prog[i] = {4'b0001, 12'($urandom)}; i++;
      end else if (sel == 6) begin
        prog[i] = {5'b01010, 11'($urandom)}; prog[i+1] = 16'($urandom); i += 2;
      end else begin
        n = $urandom_range(0, 15); k = $urandom_range(0, 5);
        prog[i] = {5'b01110, 4'(n), 7'(k)}; i++;
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 11) == 0)
            prog[i] = ($urandom_range(0, 1) == 1) ? {5'b01010, 11'($urandom)}
                                                   : {5'b01110, 11'($urandom)};
          else prog[i] = rand_plain();
          i++;
        end
      end
    end
    len = i + 6;
  endtask

  task automatic test_reset();
    clear_prog(); prog[0] = 16'h5000; prog[1] = 16'hBEEF;
    do_reset();
    vectors++;
    if (all_out() !== 39'd0) begin
      miscompares++; $display("FAIL reset_state got=%h exp=0", all_out());
    end
    step(1'b1); step(1'b1);
    rst = 1'b1; step(1'b1); rst = 1'b0;
    vectors++;
    if (all_out() !== 39'd0) begin
      miscompares++; $display("FAIL reset_after_use got=%h exp=0", all_out());
    end
  endtask

  task automatic test_short();
    clear_prog(); prog[0] = 16'h1A05;
    do_reset();
    step(1'b1);
    vectors++;
    if ({short_load, short_imm, r_field, t_field} !== {1'b1, 9'h005, 3'b001, 5'b00011}) begin
      miscompares++;
      $display("FAIL short_decode got=%b/%h/%b/%b exp=1/005/001/00011",
               short_load, short_imm, r_field, t_field);
    end
    step(1'b0);
    vectors++;
    if ({short_load, short_imm} !== {1'b0, 9'h005}) begin
      miscompares++; $display("FAIL short_cen_low got=%b/%h exp=0/005", short_load, short_imm);
    end
    step(1'b1);
    vectors++;
    if (short_load !== 1'b0) begin
      miscompares++; $display("FAIL short_one_cycle got=%b exp=0", short_load);
    end
  endtask

  task automatic test_long();
    clear_prog(); prog[0] = 16'h5000; prog[1] = 16'hBEEF;
    do_reset();
    step(1'b1);
    vectors++;
    if ({t_field, long_load} !== {5'b01010, 1'b0}) begin
      miscompares++; $display("FAIL long_first got=%b/%b exp=01010/0", t_field, long_load);
    end
    step(1'b1);
    vectors++;
    if ({long_load, long_imm, t_field, short_load} !== {1'b1, 16'hBEEF, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL long_second got=%b/%h/%b/%b exp=1/beef/00000/0",
               long_load, long_imm, t_field, short_load);
    end
    step(1'b1);
    vectors++;
    if ({long_load, long_imm} !== {1'b0, 16'hBEEF}) begin
      miscompares++; $display("FAIL long_one_cycle got=%b/%h exp=0/beef", long_load, long_imm);
    end
  endtask

  task automatic test_do_replay();
    clear_prog();
    prog[0] = 16'h7184; prog[1] = 16'h1201; prog[2] = 16'h1403; prog[3] = 16'h1605;
    run_prog(7, 1'b0, 200);
    vectors++;
    if (hold_cnt !== (CACHE_EN ? 9 : 0)) begin
      miscompares++; $display("FAIL replay_hold got=%0d exp=%0d", hold_cnt, CACHE_EN ? 9 : 0);
    end
    vectors++;
    if (issue_cnt !== (CACHE_EN ? 16 : 7)) begin
      miscompares++; $display("FAIL replay_issues got=%0d exp=%0d", issue_cnt, CACHE_EN ? 16 : 7);
    end
    vectors++;
    if (loop_busy !== 1'b0) begin
      miscompares++; $display("FAIL replay_busy_end got=%b exp=0", loop_busy);
    end
  endtask

  task automatic test_do_single();
    clear_prog();
    prog[0] = 16'h7101; prog[1] = 16'h1201; prog[2] = 16'h1403;
    prog[4] = 16'h7005; prog[5] = 16'h1605;
    run_prog(8, 1'b0, 200);
    vectors++;
    if (hold_cnt !== 0) begin
      miscompares++; $display("FAIL single_hold got=%0d exp=0", hold_cnt);
    end
    vectors++;
    if (busy_cnt !== (CACHE_EN ? 2 : 0)) begin
      miscompares++; $display("FAIL single_busy got=%0d exp=%0d", busy_cnt, CACHE_EN ? 2 : 0);
    end
    vectors++;
    if (issue_cnt !== 8) begin
      miscompares++; $display("FAIL single_issues got=%0d exp=8", issue_cnt);
    end
  endtask

  task automatic test_loop_err();
    clear_prog();
    prog[0] = 16'h7182; prog[1] = 16'h1201; prog[2] = 16'h5000;
    prog[3] = 16'h1403; prog[4] = 16'h1605;
    run_prog(7, 1'b0, 200);
    vectors++;
    if (err_cnt !== (CACHE_EN ? 1 : 0)) begin
      miscompares++; $display("FAIL err_count got=%0d exp=%0d", err_cnt, CACHE_EN ? 1 : 0);
    end
    vectors++;
    if (hold_cnt !== 0) begin
      miscompares++; $display("FAIL err_hold got=%0d exp=0", hold_cnt);
    end
  endtask

  task automatic test_rst_replay();
    clear_prog();
    prog[0] = 16'h7108; prog[1] = 16'h1201; prog[2] = 16'h1403; prog[10] = 16'h1A05;
    do_reset();
    for (int s = 0; s < 12; s++) step((s % 2) == 0);
    vectors++;
    if (pc_hold !== CACHE_EN) begin
      miscompares++; $display("FAIL pre_rst_replay got=%b exp=%b", pc_hold, CACHE_EN);
    end
    rst = 1'b1; step(1'b1); rst = 1'b0;
    vectors++;
    if (all_out() !== 39'd0) begin
      miscompares++; $display("FAIL rst_mid_loop got=%h exp=0", all_out());
    end
    pc = 8'd10;
    step(1'b1);
    vectors++;
    if ({issue, short_load, short_imm, r_field, pc_hold} !== {1'b1, 1'b1, 9'h005, 3'b001, 1'b0}) begin
      miscompares++;
      $display("FAIL post_rst_decode got=%b/%b/%h/%b/%b exp=1/1/005/001/0",
               issue, short_load, short_imm, r_field, pc_hold);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 3; r++) begin
      gen_prog(len);
      run_prog(len, 1'b1, 12000);
      vectors++;
      if (hold_cnt !== exp_replays) begin
        miscompares++; $display("FAIL random_hold run=%0d got=%0d exp=%0d", r, hold_cnt, exp_replays);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0;
    clear_prog();
    test_reset();
    test_short();
    test_long();
    test_do_replay();
    test_do_single();
    test_loop_err();
    test_rst_replay();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
